// File: rtl/mips_run_ctrl_pkg.sv
// Shared types and constants for the MIPS run-control block.
package mips_run_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    RESET_HOLD = 2'd1,
    RUN        = 2'd2,
    DONE       = 2'd3
  } run_state_e;

  // beq $0,$0,-1 : the conventional "spin here forever" end of a test program
  localparam logic [31:0] MIPS_HALT_INSN = 32'h1000FFFF;

  // Run verdict; pass/timeout outputs are decoded from this
  localparam logic [1:0] VERDICT_NONE    = 2'd0;
  localparam logic [1:0] VERDICT_PASS    = 2'd1;
  localparam logic [1:0] VERDICT_FAIL    = 2'd2;
  localparam logic [1:0] VERDICT_TIMEOUT = 2'd3;

endpackage

// File: rtl/mips_run_ctrl_halt_detect.sv
// Program-halt detector: counts consecutive commits that are either the halt
// opcode or a repeat of the previous commit PC (self-loop).
module mips_halt_detect
  import mips_run_pkg::*;
#(
  parameter int          AW          = 32,
  parameter int          HALT_REPEAT = 3,
  parameter logic [31:0] HALT_INSN   = MIPS_HALT_INSN
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          clr_i,
  input  logic          pc_valid_i,
  input  logic [AW-1:0] pc_i,
  input  logic [31:0]   instr_i,
  output logic          halt_o
);

  localparam int RW = $clog2(HALT_REPEAT + 1);

  logic [AW-1:0] last_pc_q;
  logic          last_vld_q;
  logic [RW-1:0] rpt_q;
  logic          qual;

  assign qual   = pc_valid_i && ((instr_i == HALT_INSN) || (last_vld_q && (pc_i == last_pc_q)));
  // Combinational so the top can sample the verdict in the same cycle
  assign halt_o = qual && (rpt_q == RW'(HALT_REPEAT - 1));

  // Track previous commit PC and the run of qualifying commits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      last_pc_q  <= '0;
      last_vld_q <= 1'b0;
      rpt_q      <= '0;
    end else if (clr_i) begin
      last_vld_q <= 1'b0;
      rpt_q      <= '0;
    end else if (pc_valid_i) begin
      last_pc_q  <= pc_i;
      last_vld_q <= 1'b1;
      rpt_q      <= qual ? rpt_q + RW'(1) : '0;
    end
  end

endmodule

// File: rtl/mips_run_ctrl.sv
// Run-control and verdict block: holds the core in reset, runs it, watches
// for halt or watchdog expiry and reports pass/fail/timeout.
module mips_run_ctrl
  import mips_run_pkg::*;
#(
  parameter int          AW          = 32,
  parameter int          DW          = 32,
  parameter int          CW          = 32,
  parameter int          RST_CYCLES  = 4,
  parameter int          HALT_REPEAT = 3,
  parameter int          MAX_CYCLES  = 100000,
  parameter logic [31:0] HALT_INSN   = MIPS_HALT_INSN
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic          pc_valid_i,
  input  logic [AW-1:0] pc_i,
  input  logic [31:0]   instr_i,
  input  logic [DW-1:0] result_i,
  input  logic [DW-1:0] expect_i,
  output logic          core_rst_n_o,
  output logic          running_o,
  output logic          done_o,
  output logic          pass_o,
  output logic          timeout_o,
  output logic [CW-1:0] cycle_count_o,
  output logic [CW-1:0] retire_count_o
);

  run_state_e    state_q, state_d;
  logic [CW-1:0] hold_q, hold_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [CW-1:0] ret_q, ret_d;
  logic [1:0]    verdict_q, verdict_d;
  logic          core_rst_n_q, running_q, done_q, pass_q, timeout_q;
  logic          run_commit, halt, hd_clr;

  // Commits only matter while the core is released and running
  assign run_commit = pc_valid_i && (state_q == RUN);

  mips_halt_detect #(
    .AW          (AW),
    .HALT_REPEAT (HALT_REPEAT),
    .HALT_INSN   (HALT_INSN)
  ) u_halt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .clr_i      (hd_clr),
    .pc_valid_i (run_commit),
    .pc_i       (pc_i),
    .instr_i    (instr_i),
    .halt_o     (halt)
  );

  // Next-state, counter and verdict logic
  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    cyc_d     = cyc_q;
    ret_d     = ret_q;
    verdict_d = verdict_q;
    hd_clr    = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d   = RESET_HOLD;
          hold_d    = '0;
          cyc_d     = '0;
          ret_d     = '0;
          verdict_d = VERDICT_NONE;
          hd_clr    = 1'b1;
        end
      end
      RESET_HOLD: begin
        hold_d = hold_q + CW'(1);
        if (hold_q == CW'(RST_CYCLES - 1)) state_d = RUN;
      end
      RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + CW'(1);
        if (pc_valid_i && (ret_q != '1)) ret_d = ret_q + CW'(1);
        // Halt takes priority over a coincident watchdog expiry
        if (halt) begin
          state_d   = DONE;
          verdict_d = (result_i == expect_i) ? VERDICT_PASS : VERDICT_FAIL;
        end else if (cyc_q == CW'(MAX_CYCLES - 1)) begin
          state_d   = DONE;
          verdict_d = VERDICT_TIMEOUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered outputs, all derived from next state
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      hold_q       <= '0;
      cyc_q        <= '0;
      ret_q        <= '0;
      verdict_q    <= VERDICT_NONE;
      core_rst_n_q <= 1'b0;
      running_q    <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      cyc_q        <= cyc_d;
      ret_q        <= ret_d;
      verdict_q    <= verdict_d;
      core_rst_n_q <= (state_d == RUN) || (state_d == DONE);
      running_q    <= (state_d == RUN);
      done_q       <= (state_d == DONE);
      pass_q       <= (verdict_d == VERDICT_PASS);
      timeout_q    <= (verdict_d == VERDICT_TIMEOUT);
    end
  end

  assign core_rst_n_o   = core_rst_n_q;
  assign running_o      = running_q;
  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign timeout_o      = timeout_q;
  assign cycle_count_o  = cyc_q;
  assign retire_count_o = ret_q;

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Bench for mips_run_ctrl: directed scenarios plus random traffic, checked
// every cycle against a commit-history model of the run.
module tb_mips_run_ctrl;

  localparam int          RST  = 4;
  localparam int          HR   = 3;
  localparam int          MAXC = 50;
  localparam logic [31:0] HALT = 32'h1000FFFF;

  logic        clk = 1'b0;
  logic        rst_n, start, pc_valid;
  logic [31:0] pc, instr, result, expv;
  logic        core_rst_n, running, done, pass, timeout;
  logic [31:0] cycle_count, retire_count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 0;

  always #5 clk = ~clk;

  mips_run_ctrl #(
    .AW(32), .DW(32), .CW(32), .RST_CYCLES(RST), .HALT_REPEAT(HR),
    .MAX_CYCLES(MAXC), .HALT_INSN(HALT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .pc_valid_i(pc_valid),
    .pc_i(pc), .instr_i(instr), .result_i(result), .expect_i(expv),
    .core_rst_n_o(core_rst_n), .running_o(running), .done_o(done),
    .pass_o(pass), .timeout_o(timeout), .cycle_count_o(cycle_count),
    .retire_count_o(retire_count)
  );

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 core held in reset, 2 running, 3 finished
  int          m_mode, m_hold;
  longint      m_cyc, m_ret;
  bit          m_pass, m_to;
  logic [31:0] q_pc[$];
  logic [31:0] q_in[$];

  task automatic m_clear();
    m_hold = 0; m_cyc = 0; m_ret = 0; m_pass = 0; m_to = 0;
    q_pc.delete(); q_in.delete();
  endtask

  task automatic m_reset();
    m_mode = 0;
    m_clear();
  endtask

  // Number of trailing commits in this run that are halt-like
  function automatic int trail_q();
    int n = 0;
    for (int i = q_pc.size() - 1; i >= 0; i--) begin
      if (q_in[i] == HALT || (i > 0 && q_pc[i] == q_pc[i-1])) n++;
      else break;
    end
    return n;
  endfunction

  task automatic m_step();
    bit h;
    if (!rst_n) begin m_reset(); return; end
    case (m_mode)
      0, 3: if (start) begin m_clear(); m_mode = 1; end
      1: begin m_hold++; if (m_hold == RST) m_mode = 2; end
      default: begin
        if (m_cyc < 64'hFFFF_FFFF) m_cyc++;
        if (pc_valid) begin m_ret++; q_pc.push_back(pc); q_in.push_back(instr); end
        h = pc_valid && (trail_q() >= HR);
        if (h) begin m_mode = 3; m_pass = (result == expv); m_to = 0; end
        else if (m_cyc == MAXC) begin m_mode = 3; m_to = 1; m_pass = 0; end
      end
    endcase
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h want %0h", nm, $time, act, exp);
    end
  endtask

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (chk_on) begin
      chk("core_rst_n", {63'b0, core_rst_n}, {63'b0, m_mode >= 2});
      chk("running", {63'b0, running}, {63'b0, m_mode == 2});
      chk("done", {63'b0, done}, {63'b0, m_mode == 3});
      chk("pass", {63'b0, pass}, {63'b0, m_pass});
      chk("timeout", {63'b0, timeout}, {63'b0, m_to});
      chk("cycle_count", {32'b0, cycle_count}, m_cyc);
      chk("retire_count", {32'b0, retire_count}, m_ret);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    m_step();
    #2;
  endtask

  task automatic commit(input logic [31:0] p, input logic [31:0] i);
    pc_valid = 1'b1; pc = p; instr = i;
    tick();
    pc_valid = 1'b0; instr = 32'h0;
  endtask

  task automatic rerun();
    start = 1'b1; tick(); start = 1'b0;
    repeat (RST) tick();
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (done) return;
      tick();
    end
    if (!done) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_done: done still %0b after %0d cycles, want 1", done, budget);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pc_valid = 1'b0;
    pc = '0; instr = '0; result = '0; expv = '0;
    m_reset();
    #3 chk_on = 1;

    // Reset state and release timing
    repeat (3) tick();
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_core_rst_n", {63'b0, core_rst_n}, 64'd0);
    rst_n = 1'b1;
    repeat (6) tick();
    start = 1'b1; tick(); start = 1'b0;
    repeat (3) tick();
    chk("hold_last_cycle", {63'b0, core_rst_n}, 64'd0);
    tick();
    chk("release_core_rst_n", {63'b0, core_rst_n}, 64'd1);
    chk("release_running", {63'b0, running}, 64'd1);

    // Self-loop pass
    result = 32'h2A; expv = 32'h2A;
    commit(32'h00, 0); commit(32'h04, 0); commit(32'h08, 0);
    commit(32'h08, 0); commit(32'h08, 0);
    chk("selfloop_not_yet", {63'b0, done}, 64'd0);
    commit(32'h08, 0);
    chk("selfloop_done", {63'b0, done}, 64'd1);
    chk("selfloop_pass", {63'b0, pass}, 64'd1);
    chk("selfloop_retire", {32'b0, retire_count}, 64'd6);
    chk("selfloop_cycles", {32'b0, cycle_count}, 64'd6);

    // Re-run from DONE clears everything
    start = 1'b1; tick(); start = 1'b0;
    chk("rerun_done_clr", {63'b0, done}, 64'd0);
    chk("rerun_retire_clr", {32'b0, retire_count}, 64'd0);
    chk("rerun_core_rst_n", {63'b0, core_rst_n}, 64'd0);
    repeat (RST) tick();

    // Halt opcode with wrong result
    result = 32'h29;
    commit(32'h10, HALT); commit(32'h14, HALT); commit(32'h18, HALT);
    chk("haltop_done", {63'b0, done}, 64'd1);
    chk("haltop_pass", {63'b0, pass}, 64'd0);
    chk("haltop_timeout", {63'b0, timeout}, 64'd0);

    // Interrupted repeat, then watchdog
    rerun();
    result = 32'h2A;
    commit(32'h08, 0); commit(32'h08, 0); commit(32'h0C, 0);
    commit(32'h08, 0); commit(32'h08, 0);
    chk("interrupted_no_done", {63'b0, done}, 64'd0);
    wait_done(100);
    chk("wd_timeout", {63'b0, timeout}, 64'd1);
    chk("wd_pass", {63'b0, pass}, 64'd0);
    chk("wd_cycles", {32'b0, cycle_count}, 64'd50);

    // Halt coincident with the last watchdog cycle
    rerun();
    repeat (MAXC - HR) tick();
    commit(32'h20, HALT); commit(32'h24, HALT); commit(32'h28, HALT);
    chk("coinc_done", {63'b0, done}, 64'd1);
    chk("coinc_timeout", {63'b0, timeout}, 64'd0);
    chk("coinc_pass", {63'b0, pass}, 64'd1);
    chk("coinc_cycles", {32'b0, cycle_count}, 64'd50);

    // Asynchronous abort mid-run
    rerun();
    commit(32'h00, 0); commit(32'h04, 0);
    #1 rst_n = 1'b0; m_reset();
    #1;
    chk("abort_core_rst_n", {63'b0, core_rst_n}, 64'd0);
    chk("abort_running", {63'b0, running}, 64'd0);
    chk("abort_done", {63'b0, done}, 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      start    = ($urandom_range(0, 19) == 0);
      pc_valid = $urandom_range(0, 1);
      pc       = 32'($urandom_range(0, 3)) << 2;
      instr    = ($urandom_range(0, 7) == 0) ? HALT : $urandom;
      result   = $urandom_range(0, 1) ? 32'h2A : 32'h29;
      expv     = 32'h2A;
      if ($urandom_range(0, 399) == 0) begin
        #1 rst_n = 1'b0; m_reset();
        repeat (2) tick();
        rst_n = 1'b1;
      end
      tick();
    end
    start = 1'b0; pc_valid = 1'b0;
    tick();

    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Parametrised run-control and verdict block for MIPS core bring-up and regression.
- On `start`, holds the core in reset for a programmable number of cycles, then releases it and counts cycles and retired instructions.
- Detects program halt (self-loop or halt opcode) and compares a probed result register against an expected value.
- Reports pass, fail or watchdog timeout. Sits beside the MIPS top level in both simulation harness and FPGA bring-up builds.

Parameters:
- AW, 32, PC width
- DW, 32, result/expect width
- CW, 32, cycle/retire counter width
- RST_CYCLES, 4, core reset hold length in clk cycles (legal range 1 .. 2^CW-1)
- HALT_REPEAT, 3, consecutive qualifying commits that declare halt (>=1)
- MAX_CYCLES, 100000, watchdog limit on RUN cycles (>=1)
- HALT_INSN, 32'h1000FFFF, halt opcode (beq $0,$0,-1)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock, reset is asynchronous and active-low
- start  in  1  single-cycle run request
- pc_valid  in  1  core retired an instruction this cycle
- pc  in  AW  PC of retired instruction
- instr  in  32  retired instruction word
- result  in  DW  probed result register value
- expect  in  DW  expected result, quasi-static
- core_rst_n  out  1  active-low reset to core
- running  out  1  core released and executing
- done  out  1  run finished (level)
- pass  out  1  valid when done
- timeout  out  1  watchdog fired
- cycle_count  out  CW  RUN cycles elapsed
- retire_count  out  CW  pc_valid count in RUN

Behaviour:
- Reset (rst=0, async): state=IDLE; core_rst_n=0, running=0, done=0, pass=0, timeout=0, both counters 0, halt repeat count 0, last_pc_vld=0. All outputs are registered.
- IDLE:
  - core_rst_n=0.
  - start=1 -> RESET_HOLD; hold counter loaded with 0.
- RESET_HOLD:
  - core_rst_n=0; hold counter increments.
  - After exactly RST_CYCLES cycles in RESET_HOLD -> RUN; core_rst_n=1 and running=1 from the first RUN cycle.
- RUN:
  - cycle_count increments every cycle, saturating at all-ones.
  - retire_count increments on pc_valid, saturating.
  - Qualifying commit: pc_valid && (instr==HALT_INSN || (last_pc_vld && pc==last_pc)).
  - On a qualifying commit, repeat count +1. A pc_valid that does not qualify clears the repeat count. No pc_valid leaves it unchanged.
  - last_pc<=pc and last_pc_vld<=1 on every pc_valid.
  - When the repeat count reaches HALT_REPEAT -> DONE next cycle; pass<=(result==expect), sampled in the cycle of the final qualifying commit.
  - Timeout: cycle_count==MAX_CYCLES-1 with no halt this cycle -> DONE; timeout=1, pass=0.
  - Halt and timeout in the same cycle: halt wins, timeout=0.
- DONE:
  - done=1, running=0, core_rst_n stays 1 so state remains inspectable.
  - Counters, pass and timeout are frozen.
- start ignored in RESET_HOLD and RUN.
- start in DONE: clears done, pass, timeout, counters, repeat count and last_pc_vld -> RESET_HOLD (re-run).
- Async reset mid-run: immediate return to IDLE with core_rst_n=0; no verdict.
- Latency: done rises 1 cycle after the HALT_REPEAT-th qualifying commit; core_rst_n rises RST_CYCLES+1 cycles after the start pulse.

Decomposition:
- Package mips_run_pkg:
  - state enum {IDLE, RESET_HOLD, RUN, DONE}
  - MIPS_HALT_INSN constant (32'h1000FFFF)
  - verdict encoding localparams
- Sub-module mips_halt_detect (params AW, HALT_REPEAT, HALT_INSN):
  - Inputs: clk, rst, clr, pc_valid, pc, instr.
  - Output: halt pulse.
  - Owns last_pc, last_pc_vld and the repeat counter.

Test Plan:
- Reset and release: rst low then high, start pulse at cycle 10, RST_CYCLES=4 -> core_rst_n=0 through cycle 14, =1 at cycle 15; running=1 at cycle 15.
- Self-loop pass: retire PCs 0x00,0x04,0x08,0x08,0x08,0x08 with result=expect=0x2A -> done=1 one cycle after 4th 0x08 commit (3 repeats); pass=1, retire_count=6.
- Halt opcode fail: three consecutive instr=0x1000FFFF at distinct PCs, result=0x29, expect=0x2A -> done=1, pass=0, timeout=0.
- Repeat interrupted: 0x08,0x08,0x0C,0x08,0x08 -> no done; the repeat counter restarts after 0x0C.
- Watchdog: MAX_CYCLES=50, no qualifying commits -> done=1, timeout=1, pass=0, cycle_count=50; halt coincident with cycle 50 -> timeout=0.
- Re-run and abort: start in DONE -> flags and counters clear, new RESET_HOLD; rst asserted mid-RUN -> core_rst_n=0, state IDLE immediately, done=0.
